// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg
//   Shared types and helpers for the EX-stage RV32M multiply/divide sequencer.
//   md_op_t    : the eight M-extension operations, encoded by func3
//   md_state_t : sequencer states IDLE -> PREP -> CALC -> FIXUP -> DONE
//   FUNC7_MULDIV : func7 value that selects the M extension in the decoder
package ex_muldiv_pkg;

  localparam logic [6:0] FUNC7_MULDIV = 7'b000_0001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIXUP,
    ST_DONE
  } md_state_t;

  function automatic logic op_is_div(input md_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // MUL only keeps the low half, which is identical for signed and unsigned
  // operands, so treating it as signed is harmless.
  function automatic logic op_a_signed(input md_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input md_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_step.sv
// ex_muldiv_step
//   One combinational iteration of the multiply/divide datapath.
//   Ports:
//     is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//     hi, lo  : current working pair (mul: product high/low, div: remainder/quotient)
//     operand : mul: |A| (multiplicand), div: |B| (divisor)
//     hi_nxt, lo_nxt : working pair after this step
module ex_muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Multiply consumes the multiplier from lo[0] and shifts the carry-extended
  // partial sum right into lo. Divide shifts {rem,quo} left and keeps the
  // trial subtraction only when it does not go negative.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
    shifted = {hi, lo[XLEN-1]};
    trial   = shifted - {1'b0, operand};
    hi_nxt  = sum[XLEN:1];
    lo_nxt  = {sum[0], lo[XLEN-1:1]};
    if (is_div) begin
      if (shifted >= {1'b0, operand}) begin
        hi_nxt = trial[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv
//   Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
//   Accepts one M op, stalls the pipeline for XLEN+3 cycles (2 for divide
//   special cases) and emits a one-cycle o_valid with the result.
//   Ports:
//     i_clk, i_rst_n : clock, synchronous active-low reset
//     i_valid        : op request, taken only while o_ready=1
//     i_func3        : M operation (md_op_t encoding)
//     i_A, i_B       : rs1 / rs2 operands
//     i_flush        : abandon any in-flight op
//     o_ready        : high only in IDLE
//     o_stall        : high in every non-IDLE state
//     o_valid        : one-cycle result strobe
//     o_result       : result, held until the next o_valid
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_A,
  input  logic [XLEN-1:0] i_B,
  input  logic            i_flush,
  output logic            o_ready,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t       state, state_nxt;
  md_op_t          op_q;
  logic [XLEN-1:0] a_q, b_q, opnd_q, hi_q, lo_q;
  logic            s_a, s_b;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN-1:0]   hi_step, lo_step;
  logic              is_div, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_by_zero, div_ovf, special;
  logic [XLEN-1:0]   special_result, fix_result;
  logic [2*XLEN-1:0] prod, prod_fix;

  ex_muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div (is_div),
    .hi     (hi_q),
    .lo     (lo_q),
    .operand(opnd_q),
    .hi_nxt (hi_step),
    .lo_nxt (lo_step)
  );

  // Sign handling, divide special cases and final result selection.
  always_comb begin
    is_div      = op_is_div(op_q);
    a_neg       = op_a_signed(op_q) & a_q[XLEN-1];
    b_neg       = op_b_signed(op_q) & b_q[XLEN-1];
    a_mag       = a_neg ? (~a_q + 1'b1) : a_q;
    b_mag       = b_neg ? (~b_q + 1'b1) : b_q;
    div_by_zero = is_div && (b_q == '0);
    div_ovf     = (op_q inside {OP_DIV, OP_REM}) && (a_q == XMIN) && (b_q == '1);
    special     = div_by_zero || div_ovf;

    if (div_by_zero) special_result = (op_q inside {OP_DIV, OP_DIVU}) ? '1 : a_q;
    else             special_result = (op_q == OP_DIV) ? XMIN : '0;

    prod     = {hi_q, lo_q};
    prod_fix = (s_a ^ s_b) ? (~prod + 1'b1) : prod;
    case (op_q)
      OP_MUL:                    fix_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:           fix_result = (s_a ^ s_b) ? (~lo_q + 1'b1) : lo_q;
      default:                   fix_result = s_a ? (~hi_q + 1'b1) : hi_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Flush returns any busy state to IDLE; in IDLE it blocks acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_valid && !i_flush) state_nxt = ST_PREP;
      ST_PREP:  state_nxt = special ? ST_DONE : ST_CALC;
      ST_CALC:  if (cnt_q == CNT_W'(1)) state_nxt = ST_FIXUP;
      ST_FIXUP: state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE && i_flush) state_nxt = ST_IDLE;
  end

  always_comb begin
    o_ready = (state == ST_IDLE);
    o_stall = (state != ST_IDLE);
    o_valid = (state == ST_DONE) && !i_flush;
  end

  // Datapath registers; a flushed op never touches o_result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      s_a      <= 1'b0;
      s_b      <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      o_result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid && !i_flush) begin
            op_q <= md_op_t'(i_func3);
            a_q  <= i_A;
            b_q  <= i_B;
          end
        end
        ST_PREP: begin
          if (!i_flush) begin
            s_a    <= a_neg;
            s_b    <= b_neg;
            cnt_q  <= CNT_W'(XLEN);
            hi_q   <= '0;
            lo_q   <= is_div ? a_mag : b_mag;
            opnd_q <= is_div ? b_mag : a_mag;
            if (special) o_result <= special_result;
          end
        end
        ST_CALC: begin
          if (!i_flush) begin
            hi_q  <= hi_step;
            lo_q  <= lo_step;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_FIXUP: begin
          if (!i_flush) o_result <= fix_result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv
//   Directed bench for ex_muldiv. A cycle-level reference model of the
//   sequencer's visible behaviour runs alongside and is compared against the
//   DUT on every falling edge; directed ops additionally pin result and
//   latency to hand-computed literals.
module tb_ex_muldiv;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready, stall, out_valid;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  ex_muldiv #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .i_func3 (func3),
    .i_A     (a),
    .i_B     (b),
    .i_flush (flush),
    .o_ready (ready),
    .o_stall (stall),
    .o_valid (out_valid),
    .o_result(result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // RISC-V M semantics written directly with 64-bit arithmetic.
  function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] x,
                                               input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint uy = longint'({32'b0, y});
    int     qx = $signed(x);
    int     qy = $signed(y);
    logic [63:0] p;
    case (f)
      3'b000: begin p = sx * sy; return p[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * uy; return p[63:32]; end
      3'b011: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'b100: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(qx / qy);
      end
      3'b101: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      3'b110: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(qx % qy);
      end
      default: return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] f, input logic [31:0] x,
                                       input logic [31:0] y);
    bit sp;
    sp = (f[2] && y == 32'd0) ||
         ((f == 3'b100 || f == 3'b110) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    return sp ? 2 : XLEN + 3;
  endfunction

  // Reference model: m_age is the 1-based cycle index since the accept edge;
  // the op is busy through cycle m_lat, where o_valid is expected.
  bit          mon_on = 1'b0;
  bit          m_busy = 1'b0;
  int          m_age = 0;
  int          m_lat = 0;
  logic [31:0] m_exp = '0;
  logic [31:0] m_hold = '0;

  always @(negedge clk) begin
    if (mon_on) begin
      checkOutput("cmp_ready", ready, !m_busy);
      checkOutput("cmp_stall", stall, m_busy);
      checkOutput("cmp_valid", out_valid, m_busy && m_age == m_lat && !flush);
      checkOutput("cmp_result", result, m_hold);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_hold = '0;
      end else if (m_busy) begin
        if (flush || m_age == m_lat) begin
          m_busy = 1'b0;
        end else begin
          if (m_age == m_lat - 1) m_hold = m_exp;
          m_age++;
        end
      end else if (valid && !flush) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_lat  = model_latency(func3, a, b);
        m_exp  = model_result(func3, a, b);
      end
    end
  end

  // Presents one op for a single accept edge; returns during cycle 1 (PREP).
  task automatic issueOp(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    func3 = f; a = x; b = y; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input logic [2:0] f, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] exp_res,
                               input int exp_lat);
    int n = 1;
    bit seen = 1'b0;
    issueOp(f, x, y);
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else n++;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no o_valid expected=o_valid within 60 cycles", name);
    end else begin
      checkOutput({name, "_result"}, result, exp_res);
      checkOutput({name, "_latency"}, n, exp_lat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int vcount;
    logic [31:0] seen_res;

    @(posedge clk); #1;
    mon_on = 1'b1;
    checkOutput("rst_ready", ready, 1'b1);
    checkOutput("rst_stall", stall, 1'b0);
    checkOutput("rst_valid", out_valid, 1'b0);
    checkOutput("rst_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
    applyStimulus("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 35);
    applyStimulus("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
    applyStimulus("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
    applyStimulus("mulh_n", 3'b001, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 35);
    applyStimulus("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 35);
    applyStimulus("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 35);
    applyStimulus("div_nb", 3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 35);
    applyStimulus("rem_nb", 3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         35);
    applyStimulus("divu0",  3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 2);
    applyStimulus("rem_ov", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2);
    applyStimulus("div_ov", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2);
    applyStimulus("remu0",  3'b111, 32'h0000_1234,  32'd0,         32'h0000_1234, 2);
    applyStimulus("divu",   3'b101, 32'd100,        32'd7,         32'd14,        35);
    applyStimulus("remu",   3'b111, 32'd100,        32'd7,         32'd2,         35);

    // Flush during CALC step 10 (cycle 11 after accept).
    issueOp(3'b000, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("flush_pre_stall", stall, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_stall", stall, 1'b0);
    checkOutput("flush_result", result, 32'd2);
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    checkOutput("flush_no_valid", vcount, 0);

    // Reset in the middle of CALC.
    issueOp(3'b000, 32'd7, 32'd3);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midrst_result", result, 32'd0);
    checkOutput("midrst_stall", stall, 1'b0);
    checkOutput("midrst_ready", ready, 1'b1);
    checkOutput("midrst_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    checkOutput("midrst_no_valid", vcount, 0);

    // Requests while busy are dropped: exactly one o_valid for the DIVU.
    issueOp(3'b101, 32'd100, 32'd7);
    func3 = 3'b000; a = 32'd9; b = 32'd9; valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    valid = 1'b0;
    vcount = 0;
    seen_res = '0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid) begin
        vcount++;
        seen_res = result;
      end
    end
    checkOutput("busy_valid_count", vcount, 1);
    checkOutput("busy_result", seen_res, 32'd14);

    // Flush and valid together in IDLE: nothing accepted.
    @(posedge clk); #1;
    func3 = 3'b000; a = 32'd2; b = 32'd2; valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    checkOutput("idle_flush_ready", ready, 1'b1);
    checkOutput("idle_flush_stall", stall, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
